// File: rtl/clock_pkg.sv
// Shared constants and types for the clock core's button front end.
package clock_pkg;

  // Default timing at a 50 MHz system clock.
  localparam int DB_CYCLES_DEF    = 1_000_000;   // 20 ms debounce
  localparam int DELAY_CYCLES_DEF = 25_000_000;  // 500 ms before first repeat
  localparam int RATE_CYCLES_DEF  = 5_000_000;   // 100 ms between repeats

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } btn_state_e;

  // Bits needed to count 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop synchronizer, debouncer and press/hold-to-repeat FSM.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | button released; a debounced press fires the first pulse
// DELAY  | held after the first pulse; waiting out the initial hold time
// REPEAT | held past the initial hold; pulsing every repeat interval
module button_channel
  import clock_pkg::*;
#(
  parameter int ACTIVE_LOW   = 1,
  parameter int DB_CYCLES    = DB_CYCLES_DEF,
  parameter int DELAY_CYCLES = DELAY_CYCLES_DEF,
  parameter int RATE_CYCLES  = RATE_CYCLES_DEF,
  parameter int REPEAT_EN    = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pulse
);

  localparam int DB_W    = cnt_width(DB_CYCLES);
  localparam int TMR_MAX = (DELAY_CYCLES > RATE_CYCLES) ? DELAY_CYCLES : RATE_CYCLES;
  localparam int TMR_W   = cnt_width(TMR_MAX);

  localparam logic              RELEASED_RAW = (ACTIVE_LOW != 0);
  localparam logic [DB_W-1:0]   DB_LAST      = DB_W'(DB_CYCLES - 1);
  localparam logic [TMR_W-1:0]  DELAY_LAST   = TMR_W'(DELAY_CYCLES - 1);
  localparam logic [TMR_W-1:0]  RATE_LAST    = TMR_W'(RATE_CYCLES - 1);

  logic             sync_q1, sync_q2;
  logic             pressed;
  logic [DB_W-1:0]  db_cnt_q;
  btn_state_e       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             fsm_pulse;

  // Synchronizer resets to the released pin level so reset never looks like a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= RELEASED_RAW;
      sync_q2 <= RELEASED_RAW;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  assign pressed = sync_q2 ^ RELEASED_RAW;

  // Debounce: accept a new level only after DB_CYCLES consecutive cycles of disagreement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt_q  <= '0;
      btn_level <= 1'b0;
    end else if (pressed != btn_level) begin
      if (db_cnt_q == DB_LAST) begin
        db_cnt_q  <= '0;
        btn_level <= ~btn_level;
      end else begin
        db_cnt_q <= db_cnt_q + DB_W'(1);
      end
    end else begin
      db_cnt_q <= '0;
    end
  end

  // FSM state and shared hold/repeat timer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  // Next state, timer and pulse request; a release always wins over a terminal count.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    fsm_pulse = 1'b0;
    case (state_q)
      IDLE: begin
        tmr_d = '0;
        if (btn_level) begin
          fsm_pulse = 1'b1;
          state_d   = DELAY;
        end
      end
      DELAY: begin
        if (!btn_level) begin
          state_d = IDLE;
          tmr_d   = '0;
        end else if (tmr_q == DELAY_LAST) begin
          tmr_d = '0;
          if (REPEAT_EN != 0) begin
            fsm_pulse = 1'b1;
            state_d   = REPEAT;
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      REPEAT: begin
        if (!btn_level) begin
          state_d = IDLE;
          tmr_d   = '0;
        end else if (tmr_q == RATE_LAST) begin
          tmr_d     = '0;
          fsm_pulse = 1'b1;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  // Gated, registered strobe; pulses arriving while disabled are simply dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) btn_pulse <= 1'b0;
    else       btn_pulse <= fsm_pulse & enable;
  end

endmodule

// File: rtl/button_pulse_conditioner.sv
// Debounced single-pulse + hold-to-repeat front end for the time-setting buttons.
module button_pulse_conditioner
  import clock_pkg::*;
#(
  parameter int N_BUTTONS    = 2,
  parameter int ACTIVE_LOW   = 1,
  parameter int DB_CYCLES    = DB_CYCLES_DEF,
  parameter int DELAY_CYCLES = DELAY_CYCLES_DEF,
  parameter int RATE_CYCLES  = RATE_CYCLES_DEF,
  parameter int REPEAT_EN    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [N_BUTTONS-1:0] btn_raw,
  output logic [N_BUTTONS-1:0] btn_level,
  output logic [N_BUTTONS-1:0] btn_pulse
);

  // Independent, identical channels sharing only clock, reset and enable.
  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
    button_channel #(
      .ACTIVE_LOW  (ACTIVE_LOW),
      .DB_CYCLES   (DB_CYCLES),
      .DELAY_CYCLES(DELAY_CYCLES),
      .RATE_CYCLES (RATE_CYCLES),
      .REPEAT_EN   (REPEAT_EN)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .btn_raw  (btn_raw[i]),
      .btn_level(btn_level[i]),
      .btn_pulse(btn_pulse[i])
    );
  end

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Bench for button_pulse_conditioner: directed scenarios plus random press patterns,
// checked every cycle against a window/age based reference model.
module tb_button_pulse_conditioner;

  localparam int N    = 2;
  localparam int DB   = 4;
  localparam int DLY  = 20;
  localparam int RATE = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_pulse;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // reference model state
  logic [N-1:0] m_level, m_pulse, m_fsm, m_samp;
  logic         m_s_hist [N][DB];
  int           m_age [N];

  // observations of the DUT
  logic [N-1:0] prev_level, prev_pulse;
  int rise_cyc [N];
  int fall_cyc [N];
  int last_pulse [N];
  int pulse_cnt [N];
  int hold_left [N];

  always #5 clk = ~clk;

  button_pulse_conditioner #(
    .N_BUTTONS(N), .ACTIVE_LOW(1), .DB_CYCLES(DB),
    .DELAY_CYCLES(DLY), .RATE_CYCLES(RATE), .REPEAT_EN(1)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .btn_raw(btn_raw), .btn_level(btn_level), .btn_pulse(btn_pulse)
  );

  // A held button pulses on press (age 0), after DLY cycles, then every RATE cycles.
  function automatic bit pulse_age(input int age);
    return (age == 0) || (age == DLY) || (age > DLY && ((age - DLY) % RATE) == 0);
  endfunction

  task automatic model_reset();
    m_level = '0; m_pulse = '0; m_fsm = '0; m_samp = '0;
    for (int c = 0; c < N; c++) begin
      m_age[c] = -1;
      for (int k = 0; k < DB; k++) m_s_hist[c][k] = 1'b0;
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    logic [N-1:0] norm;
    logic         old;
    bit           all_diff;
    norm    = ~btn_raw;
    m_pulse = m_fsm & {N{enable}};
    for (int c = 0; c < N; c++) begin
      all_diff = 1'b1;
      for (int k = 0; k < DB; k++) if (m_s_hist[c][k] == m_level[c]) all_diff = 1'b0;
      old = m_level[c];
      if (all_diff) m_level[c] = ~m_level[c];
      for (int k = DB - 1; k > 0; k--) m_s_hist[c][k] = m_s_hist[c][k-1];
      m_s_hist[c][0] = m_samp[c];
      m_samp[c] = norm[c];
      if (m_level[c]) m_age[c] = old ? m_age[c] + 1 : 0;
      else            m_age[c] = -1;
      m_fsm[c] = m_level[c] && pulse_age(m_age[c]);
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    for (int c = 0; c < N; c++) begin
      rise_cyc[c] = -1; fall_cyc[c] = -1; last_pulse[c] = -1; pulse_cnt[c] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
    cyc++;
    vectors++;
    assert (btn_level === m_level) else begin
      miscompares++;
      $error("FAIL level cyc=%0d observed %b expected %b", cyc, btn_level, m_level);
    end
    vectors++;
    assert (btn_pulse === m_pulse) else begin
      miscompares++;
      $error("FAIL pulse cyc=%0d observed %b expected %b", cyc, btn_pulse, m_pulse);
    end
    vectors++;
    assert ((btn_pulse & prev_pulse) === {N{1'b0}}) else begin
      miscompares++;
      $error("FAIL back_to_back cyc=%0d observed %b expected 0", cyc, btn_pulse & prev_pulse);
    end
    for (int c = 0; c < N; c++) begin
      if (btn_level[c] && !prev_level[c]) rise_cyc[c] = cyc;
      if (!btn_level[c] && prev_level[c]) fall_cyc[c] = cyc;
      if (btn_pulse[c]) begin pulse_cnt[c]++; last_pulse[c] = cyc; end
    end
    prev_level = btn_level;
    prev_pulse = btn_pulse;
  endtask

  task automatic idle(input int n);
    btn_raw = '1;
    repeat (n) tick();
  endtask

  initial begin
    int t0, p, tr;
    reset = 1'b1; enable = 1'b1; btn_raw = '1;
    prev_level = '0; prev_pulse = '0;
    clear_obs();
    model_reset();
    #1;
    chk("reset_level", int'(btn_level), 0);
    chk("reset_pulse", int'(btn_pulse), 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    idle(5);

    // clean press on channel 0
    clear_obs(); t0 = cyc;
    btn_raw[0] = 1'b0;
    repeat (10) tick();
    chk("clean_rise", rise_cyc[0] - t0, 6);
    chk("clean_pulse_at", last_pulse[0] - t0, 7);
    chk("clean_pulse_cnt", pulse_cnt[0], 1);
    chk("clean_other_ch", pulse_cnt[1], 0);
    idle(20);

    // bounce then settle low
    clear_obs();
    for (int i = 0; i < 6; i++) begin
      btn_raw[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) tick();
    end
    chk("bounce_no_level", rise_cyc[0], -1);
    btn_raw[0] = 1'b0; t0 = cyc;
    repeat (10) tick();
    chk("bounce_pulse_at", last_pulse[0] - t0, 7);
    chk("bounce_pulse_cnt", pulse_cnt[0], 1);
    idle(20);

    // hold to repeat, then release
    clear_obs(); t0 = cyc;
    btn_raw[0] = 1'b0;
    repeat (7) tick();
    p = last_pulse[0];
    chk("hold_first", p - t0, 7);
    repeat (52) tick();
    btn_raw[0] = 1'b1; tr = cyc;
    repeat (30) tick();
    chk("hold_pulse_cnt", pulse_cnt[0], 9);
    chk("hold_last_repeat", last_pulse[0] - p, 55);
    chk("release_fall", fall_cyc[0] - tr, 6);
    idle(10);

    // enable gating
    clear_obs(); t0 = cyc;
    enable = 1'b0;
    btn_raw[0] = 1'b0;
    repeat (29) tick();
    chk("gated_none", pulse_cnt[0], 0);
    enable = 1'b1;
    repeat (10) tick();
    chk("gated_cnt", pulse_cnt[0], 2);
    chk("gated_last", last_pulse[0] - t0, 37);
    idle(20);

    // simultaneous presses
    clear_obs(); t0 = cyc;
    btn_raw = '0;
    repeat (10) tick();
    chk("simul_p0", last_pulse[0] - t0, 7);
    chk("simul_p1", last_pulse[1] - t0, 7);
    chk("simul_cnt1", pulse_cnt[1], 1);
    idle(20);

    // reset while held
    clear_obs(); t0 = cyc;
    btn_raw[0] = 1'b0;
    repeat (17) tick();
    reset = 1'b1;
    #1;
    chk("rst_async_level", int'(btn_level), 0);
    chk("rst_async_pulse", int'(btn_pulse), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    prev_level = btn_level; prev_pulse = btn_pulse;
    clear_obs(); tr = cyc;
    repeat (10) tick();
    chk("rst_new_rise", rise_cyc[0] - tr, 6);
    chk("rst_new_pulse", last_pulse[0] - tr, 7);
    idle(20);

    // random press patterns with occasional long holds and enable toggles
    for (int c = 0; c < N; c++) hold_left[c] = 0;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < N; c++) begin
        if (hold_left[c] == 0) begin
          btn_raw[c] = ~btn_raw[c];
          hold_left[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 70))
                                                     : int'($urandom_range(1, 6));
        end else begin
          hold_left[c]--;
        end
      end
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      tick();
    end
    enable = 1'b1;
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/button_pulse_conditioner.md
# button_pulse_conditioner

Converts raw, bouncing, asynchronous push-button inputs into clean single-cycle increment pulses with hold-to-repeat, for the time-setting inputs of the clock core. It sits between the board KEY pins and the clock core's hour/minute increment inputs. Each held press yields exactly one pulse, plus timed repeats, instead of one increment per clock cycle. All channels are independent and identical.

## Interface
Parameters:
- N_BUTTONS, 2, number of independent channels (bit 0 = minutes, bit 1 = hours).
- ACTIVE_LOW, 1, raw input polarity; 1 = pressed when pin is 0 (DE10-Lite KEYs).
- DB_CYCLES, 1_000_000, stable cycles required to accept a level change (20 ms at 50 MHz); must be ≥2.
- DELAY_CYCLES, 25_000_000, hold time from first pulse to first repeat (500 ms).
- RATE_CYCLES, 5_000_000, interval between repeats (100 ms).
- REPEAT_EN, 1, 0 disables auto-repeat.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  pulse gate; tied to the set-mode switch.
- btn_raw  in  N_BUTTONS  raw pin levels, asynchronous.
- btn_level  out  N_BUTTONS  debounced pressed level (1 = pressed).
- btn_pulse  out  N_BUTTONS  one-cycle increment strobe.

## Operation
- Sync: 2-flop synchronizer per channel, then polarity normalisation (pressed = 1).
- Debounce: the counter increments while the synced value ≠ btn_level and clears when they are equal. When the count reaches DB_CYCLES-1 with the values still unequal, btn_level toggles and the counter clears. Any bounce restarts the count.
- Per-channel FSM on btn_level; a single counter is shared by DELAY and REPEAT:
  - IDLE: btn_level rises → pulse, counter := 0, go to DELAY.
  - DELAY: release → IDLE. Otherwise, counter == DELAY_CYCLES-1 → pulse, counter := 0, go to REPEAT (if REPEAT_EN = 0, stay in DELAY and do not pulse).
  - REPEAT: release → IDLE. Otherwise, counter == RATE_CYCLES-1 → pulse, counter := 0.
- btn_pulse = registered (FSM pulse AND enable). With enable low, the FSM still runs and pulses are dropped, not queued.
- Counter widths come from $clog2 of the parameter values; the counters never wrap because they clear at their terminal value.
- Simultaneous presses on several channels produce concurrent pulses. There is no arbitration.

## Timing
- Reset values: btn_level = 0, btn_pulse = 0, FSM = IDLE, all counters = 0, synchronizer flops = released level.
- Press latency:
  - Raw edge stable from cycle 0.
  - Synced value changes at edge 2.
  - btn_level rises at edge 2+DB_CYCLES.
  - btn_pulse is high for exactly cycle 3+DB_CYCLES.
- Release latency: btn_level falls DB_CYCLES+2 cycles after the raw edge; no pulse on release.
- First repeat is DELAY_CYCLES after the first pulse; subsequent repeats are every RATE_CYCLES.
- btn_pulse is never high for two consecutive cycles.
- Release in the same cycle a repeat terminal count is hit: the release wins, with no pulse and the FSM returns to IDLE.
- Reset mid-operation: all outputs drop asynchronously. A button still held after reset is treated as a new press after DB_CYCLES+3 cycles.

## Structure
- Shared package `clock_pkg`: default cycle constants (DB/DELAY/RATE at 50 MHz), FSM state enum {IDLE, DELAY, REPEAT}.
- Sub-module `button_channel`: one synchronizer, debouncer, and FSM. The top level generates N_BUTTONS instances and drives the shared enable.

## Test plan
Sim parameters: DB_CYCLES=4, DELAY_CYCLES=20, RATE_CYCLES=5, ACTIVE_LOW=1.
- Clean press: btn_raw[0] 1→0, held 10 cycles → btn_level[0] rises at cycle 6, one btn_pulse[0] in cycle 7, btn_pulse[1] stays 0.
- Bounce: btn_raw toggles every 2 cycles for 12 cycles, then stays low → no change in btn_level during bouncing, exactly one pulse 7 cycles after the final edge.
- Hold: held 60 cycles after the first pulse → pulses at first+20, +25, +30, …, +55 (8 total). Release → btn_level falls after 6 cycles, no further pulses.
- Enable gating: enable = 0 during the press → no pulses. Enable raised at first+22 while held → next pulse at first+25.
- Simultaneous: both channels pressed in the same cycle → both btn_pulse bits high in the same single cycle.
- Reset mid-hold: reset asserted for 1 cycle at first+10 with the button still held → outputs 0 immediately, new pulse 7 cycles after reset deasserts.
